// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the memory arbiter: the FSM state enum,
// default bus widths and the width of a client index.
package memory_arbiter_pkg;

    localparam int ADDR_W_DEF  = 17;
    localparam int DATA_W_DEF  = 8;
    localparam int MAX_CLIENTS = 4;
    localparam int IDX_W       = $clog2(MAX_CLIENTS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ1,
        ST_READ2,
        ST_ACK
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter_picker.sv
// Combinational winner select over the request vector.
// MEMARB_ROUND_ROBIN_EN: search starts at i_pointer; otherwise lowest index wins.
module memory_arbiter_picker
    import memory_arbiter_pkg::*;
#(
    parameter int CLIENTS = 2
) (
    input  logic [CLIENTS-1:0] i_request,
    input  logic [IDX_W-1:0]   i_pointer,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_winner
);

`ifdef MEMARB_ROUND_ROBIN_EN
    // Scan offsets from the far end so the smallest offset from the pointer is written last.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        o_valid  = 1'b0;
        o_winner = '0;
        for (int k = CLIENTS - 1; k >= 0; k--) begin
            for (int i = 0; i < CLIENTS; i++) begin
                if (((int'(i_pointer) + k) % CLIENTS) == i && i_request[i]) begin
                    o_valid  = 1'b1;
                    o_winner = IDX_W'(i);
                end
            end
        end
    end
`else
    logic w_unused_pointer;
    assign w_unused_pointer = ^i_pointer;

    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        o_valid  = 1'b0;
        o_winner = '0;
        for (int i = CLIENTS - 1; i >= 0; i--) begin
            if (i_request[i]) begin
                o_valid  = 1'b1;
                o_winner = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Shares the memory manager's CPU port between CLIENTS requesters, one access at a time.
// MEMARB_ROUND_ROBIN_EN selects round-robin arbitration; default is fixed priority.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int CLIENTS = 2,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                           clock,
    input  logic                           resetN,
    input  logic [CLIENTS-1:0]             clientRequest,
    input  logic [CLIENTS-1:0]             clientWrite,
    input  logic [CLIENTS-1:0][ADDR_W-1:0] clientAddress,
    input  logic [CLIENTS-1:0][DATA_W-1:0] clientWriteData,
    output logic [CLIENTS-1:0]             clientAck,
    output logic [DATA_W-1:0]              clientReadData,
    output logic                           memoryWriteRequest,
    output logic [ADDR_W-1:0]              memoryWriteAddress,
    output logic [DATA_W-1:0]              memoryWriteData,
    input  logic                           memoryWriteComplete,
    output logic [ADDR_W-1:0]              memoryReadAddress,
    input  logic [DATA_W-1:0]              memoryReadData,
    input  logic                           slotDone
);

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_winner;
    logic [CLIENTS-1:0] r_ack;
    logic [DATA_W-1:0]  r_read_data;
    logic               r_wr_req;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic [ADDR_W-1:0]  r_rd_addr;

    logic               w_valid;
    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W-1:0]   w_pointer;
    logic               w_sel_write;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic [CLIENTS-1:0] w_ack_onehot;

    memory_arbiter_picker #(.CLIENTS(CLIENTS)) u_picker (
        .i_request (clientRequest),
        .i_pointer (w_pointer),
        .o_valid   (w_valid),
        .o_winner  (w_winner)
    );

    always_comb begin
        w_sel_write  = 1'b0;
        w_sel_addr   = '0;
        w_sel_data   = '0;
        w_ack_onehot = '0;
        for (int i = 0; i < CLIENTS; i++) begin
            if (IDX_W'(i) == w_winner) begin
                w_sel_write = clientWrite[i];
                w_sel_addr  = clientAddress[i];
                w_sel_data  = clientWriteData[i];
            end
            w_ack_onehot[i] = (IDX_W'(i) == r_winner);
        end
    end

    // The ack is loaded on the way into ST_ACK so the pulse is high exactly during ACK.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state     <= ST_IDLE;
            r_winner    <= '0;
            r_ack       <= '0;
            r_read_data <= '0;
            r_wr_req    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rd_addr   <= '0;
        end else begin
            // NOTE: non-blocking assignments only, so every register samples pre-edge values.
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_winner <= w_winner;
                        if (w_sel_write) begin
                            r_wr_addr <= w_sel_addr;
                            r_wr_data <= w_sel_data;
                            r_wr_req  <= 1'b1;
                            r_state   <= ST_WRITE;
                        end else begin
                            r_rd_addr <= w_sel_addr;
                            r_state   <= ST_READ1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (memoryWriteComplete) begin
                        r_wr_req <= 1'b0;
                        r_ack    <= w_ack_onehot;
                        r_state  <= ST_ACK;
                    end
                end
                // First slot may have latched the previous address; its data is discarded.
                ST_READ1: begin
                    if (slotDone) begin
                        r_state <= ST_READ2;
                    end
                end
                ST_READ2: begin
                    if (slotDone) begin
                        r_read_data <= memoryReadData;
                        r_ack       <= w_ack_onehot;
                        r_state     <= ST_ACK;
                    end
                end
                ST_ACK:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEMARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_pointer;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_pointer <= '0;
        end else if (r_state == ST_ACK) begin
            r_pointer <= (r_winner == IDX_W'(CLIENTS - 1)) ? '0 : r_winner + IDX_W'(1);
        end
    end

    assign w_pointer = r_pointer;
`else
    assign w_pointer = '0;
`endif

    assign clientAck          = r_ack;
    assign clientReadData     = r_read_data;
    assign memoryWriteRequest = r_wr_req;
    assign memoryWriteAddress = r_wr_addr;
    assign memoryWriteData    = r_wr_data;
    assign memoryReadAddress  = r_rd_addr;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: the memory-manager handshakes are driven by hand
// so every expected value follows from a fixed cycle schedule.
module tb_memory_arbiter;

    logic             clock = 1'b0;
    logic             resetN;
    logic [1:0]       clientRequest;
    logic [1:0]       clientWrite;
    logic [1:0][16:0] clientAddress;
    logic [1:0][7:0]  clientWriteData;
    logic [1:0]       clientAck;
    logic [7:0]       clientReadData;
    logic             memoryWriteRequest;
    logic [16:0]      memoryWriteAddress;
    logic [7:0]       memoryWriteData;
    logic             memoryWriteComplete;
    logic [16:0]      memoryReadAddress;
    logic [7:0]       memoryReadData;
    logic             slotDone;

    int n_checks = 0;
    int n_fail   = 0;

    memory_arbiter #(.CLIENTS(2), .ADDR_W(17), .DATA_W(8)) dut (
        .clock               (clock),
        .resetN              (resetN),
        .clientRequest       (clientRequest),
        .clientWrite         (clientWrite),
        .clientAddress       (clientAddress),
        .clientWriteData     (clientWriteData),
        .clientAck           (clientAck),
        .clientReadData      (clientReadData),
        .memoryWriteRequest  (memoryWriteRequest),
        .memoryWriteAddress  (memoryWriteAddress),
        .memoryWriteData     (memoryWriteData),
        .memoryWriteComplete (memoryWriteComplete),
        .memoryReadAddress   (memoryReadAddress),
        .memoryReadData      (memoryReadData),
        .slotDone            (slotDone)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock: inputs change at the falling edge, outputs are checked there too.
    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        logic [1:0] exp_ack;
        resetN              = 1'b0;
        clientRequest       = '0;
        clientWrite         = '0;
        clientAddress       = '0;
        clientWriteData     = '0;
        memoryWriteComplete = 1'b0;
        memoryReadData      = '0;
        slotDone            = 1'b0;
        repeat (3) cyc();

        check("reset_ack",    32'(clientAck), 32'h0);
        check("reset_wreq",   32'(memoryWriteRequest), 32'h0);
        check("reset_waddr",  32'(memoryWriteAddress), 32'h0);
        check("reset_wdata",  32'(memoryWriteData), 32'h0);
        check("reset_raddr",  32'(memoryReadAddress), 32'h0);
        check("reset_rdata",  32'(clientReadData), 32'h0);
        resetN = 1'b1;
        cyc();

        // Stray handshake pulses with nothing requested.
        memoryWriteComplete = 1'b1;
        slotDone            = 1'b1;
        cyc();
        memoryWriteComplete = 1'b0;
        slotDone            = 1'b0;
        cyc();
        check("spurious_ack",   32'(clientAck), 32'h0);
        check("spurious_wreq",  32'(memoryWriteRequest), 32'h0);
        check("spurious_raddr", 32'(memoryReadAddress), 32'h0);

        // Client 0 writes 0x5A to 0x01234, memory manager completes after 3 cycles.
        clientRequest[0]   = 1'b1;
        clientWrite[0]     = 1'b1;
        clientAddress[0]   = 17'h01234;
        clientWriteData[0] = 8'h5A;
        cyc();
        check("wr0_req_up",  32'(memoryWriteRequest), 32'h1);
        check("wr0_addr",    32'(memoryWriteAddress), 32'h01234);
        check("wr0_data",    32'(memoryWriteData), 32'h5A);
        check("wr0_no_ack",  32'(clientAck), 32'h0);
        cyc();
        cyc();
        check("wr0_req_held", 32'(memoryWriteRequest), 32'h1);
        memoryWriteComplete = 1'b1;
        cyc();
        memoryWriteComplete = 1'b0;
        check("wr0_req_drop", 32'(memoryWriteRequest), 32'h0);
        check("wr0_ack",      32'(clientAck), 32'h1);
        check("wr0_addr_ack", 32'(memoryWriteAddress), 32'h01234);
        check("wr0_data_ack", 32'(memoryWriteData), 32'h5A);
        clientRequest[0] = 1'b0;
        cyc();
        check("wr0_ack_single", 32'(clientAck), 32'h0);
        check("wr0_addr_after", 32'(memoryWriteAddress), 32'h01234);
        check("wr0_data_after", 32'(memoryWriteData), 32'h5A);

        // Client 1 reads 0x1FFFF; a slotDone in the grant cycle must not count.
        clientRequest[1] = 1'b1;
        clientWrite[1]   = 1'b0;
        clientAddress[1] = 17'h1FFFF;
        slotDone         = 1'b1;
        cyc();
        slotDone = 1'b0;
        check("rd1_raddr",  32'(memoryReadAddress), 32'h1FFFF);
        check("rd1_no_ack", 32'(clientAck), 32'h0);
        check("rd1_no_wreq", 32'(memoryWriteRequest), 32'h0);
        cyc();
        cyc();
        memoryReadData = 8'h11;
        slotDone       = 1'b1;
        cyc();
        slotDone = 1'b0;
        check("rd1_first_slot_ack",  32'(clientAck), 32'h0);
        check("rd1_first_slot_data", 32'(clientReadData), 32'h0);
        cyc();
        cyc();
        cyc();
        memoryReadData = 8'hC3;
        slotDone       = 1'b1;
        cyc();
        slotDone       = 1'b0;
        memoryReadData = 8'h00;
        check("rd1_ack",  32'(clientAck), 32'h2);
        check("rd1_data", 32'(clientReadData), 32'hC3);
        clientRequest[1] = 1'b0;
        cyc();
        check("rd1_ack_single", 32'(clientAck), 32'h0);
        check("rd1_data_held",  32'(clientReadData), 32'hC3);

        // Both clients write continuously.
        clientRequest      = 2'b11;
        clientWrite        = 2'b11;
        clientAddress[0]   = 17'h00100;
        clientWriteData[0] = 8'h10;
        clientAddress[1]   = 17'h00200;
        clientWriteData[1] = 8'h21;
        for (int n = 0; n < 4; n++) begin
`ifdef MEMARB_ROUND_ROBIN_EN
            exp_ack = (n % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_ack = 2'b01;
`endif
            cyc();
            check("both_grant_addr", 32'(memoryWriteAddress), (exp_ack == 2'b01) ? 32'h00100 : 32'h00200);
            check("both_grant_data", 32'(memoryWriteData), (exp_ack == 2'b01) ? 32'h10 : 32'h21);
            memoryWriteComplete = 1'b1;
            cyc();
            memoryWriteComplete = 1'b0;
            check("both_ack", 32'(clientAck), 32'(exp_ack));
            cyc();
        end
        clientRequest = 2'b00;
        cyc();
        check("both_idle_wreq", 32'(memoryWriteRequest), 32'h0);

        // Reset pulsed low in the middle of a write.
        clientRequest[0]   = 1'b1;
        clientWrite[0]     = 1'b1;
        clientAddress[0]   = 17'h0ABCD;
        clientWriteData[0] = 8'h77;
        cyc();
        check("rst_wr_req_up", 32'(memoryWriteRequest), 32'h1);
        #2;
        resetN = 1'b0;
        #1;
        check("rst_async_wreq",  32'(memoryWriteRequest), 32'h0);
        check("rst_async_waddr", 32'(memoryWriteAddress), 32'h0);
        check("rst_async_wdata", 32'(memoryWriteData), 32'h0);
        check("rst_async_raddr", 32'(memoryReadAddress), 32'h0);
        check("rst_async_rdata", 32'(clientReadData), 32'h0);
        clientRequest = 2'b00;
        @(negedge clock);
        resetN              = 1'b1;
        memoryWriteComplete = 1'b1;
        cyc();
        memoryWriteComplete = 1'b0;
        check("rst_stray_ack",  32'(clientAck), 32'h0);
        check("rst_stray_wreq", 32'(memoryWriteRequest), 32'h0);
        cyc();
        check("rst_stray_ack2", 32'(clientAck), 32'h0);

        // Service resumes normally after the reset.
        clientRequest[1]   = 1'b1;
        clientWrite[1]     = 1'b1;
        clientAddress[1]   = 17'h00042;
        clientWriteData[1] = 8'h99;
        cyc();
        check("post_rst_wreq",  32'(memoryWriteRequest), 32'h1);
        check("post_rst_waddr", 32'(memoryWriteAddress), 32'h00042);
        check("post_rst_wdata", 32'(memoryWriteData), 32'h99);
        memoryWriteComplete = 1'b1;
        cyc();
        memoryWriteComplete = 1'b0;
        check("post_rst_ack", 32'(clientAck), 32'h2);
        clientRequest = 2'b00;
        cyc();
        check("post_rst_ack_single", 32'(clientAck), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
